// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//
// First-word-fall-through FIFO with valid/ready handshakes on both sides,
// a fill-level output, programmable almost-full/almost-empty flags and a
// synchronous flush. Depth may be any value >= 2, including non-powers of two.
//
// Datapath: words are written into an inferred dual-port block RAM with a
// registered read. A prefetch engine reads ahead into the RAM output register
// (stage 1), which feeds the output register (stage 2). A word pushed into an
// empty FIFO therefore reaches m_data exactly two edges after its push.
// Capacity is NumWords words. This count includes the words sitting in the
// read and output stages. Their RAM slots are not overwritten until the word
// has been consumed, because level still counts them.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   flush         synchronous clear of contents (same effect as reset)
//   s_data        write data
//   s_valid       producer offers s_data
//   s_ready       FIFO can accept a word (level != NumWords, low during rst)
//   m_data        head-of-queue word (registered)
//   m_valid       m_data holds a valid word (registered)
//   m_ready       consumer takes m_data
//   level         words accepted and not yet consumed
//   almost_full   level >= AlmostFullLevel
//   almost_empty  level <= AlmostEmptyLevel
// -----------------------------------------------------------------------------
module stream_fifo #(
    parameter int WordLengthBits   = 8,
    parameter int NumWords         = 128,
    parameter int AlmostFullLevel  = NumWords - 4,
    parameter int AlmostEmptyLevel = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [WordLengthBits-1:0]         s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [WordLengthBits-1:0]         m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(NumWords+1)-1:0]     level,
    output logic                              almost_full,
    output logic                              almost_empty
);

    localparam int LevelBits = $clog2(NumWords + 1);
    localparam int AddrBits  = (NumWords > 1) ? $clog2(NumWords) : 1;

    localparam logic [LevelBits-1:0] FULL_LEVEL = LevelBits'(NumWords);
    localparam logic [AddrBits-1:0]  LAST_ADDR  = AddrBits'(NumWords - 1);
    localparam logic [LevelBits-1:0] LEVEL_ONE  = LevelBits'(1);
    localparam logic [AddrBits-1:0]  ADDR_ONE   = AddrBits'(1);

    // Storage
    logic [WordLengthBits-1:0] mem [NumWords];
    logic [WordLengthBits-1:0] rd_data_reg;
    logic [WordLengthBits-1:0] m_data_reg;

    // Control state
    logic [AddrBits-1:0]  wr_ptr_reg,   wr_ptr_next;
    logic [AddrBits-1:0]  rd_ptr_reg,   rd_ptr_next;
    logic [LevelBits-1:0] level_reg,    level_next;
    logic [LevelBits-1:0] unread_reg,   unread_next;   // words in RAM not yet read out
    logic                 rd_valid_reg, rd_valid_next; // RAM output register holds a word
    logic                 m_valid_reg,  m_valid_next;

    // Handshake events
    logic push;
    logic pop;
    logic move;   // RAM output register -> output register
    logic issue;  // RAM read into the RAM output register

    // Pointer increment with explicit wrap, so no address >= NumWords is ever
    // produced even when NumWords is not a power of two.
    function automatic logic [AddrBits-1:0] next_addr(input logic [AddrBits-1:0] addr);
        return (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;
    endfunction

    // s_ready depends only on registered level (and reset), never on s_valid
    // or m_ready.
    assign s_ready = !rst && (level_reg != FULL_LEVEL);

    assign push = s_valid && s_ready;
    assign pop  = m_valid_reg && m_ready;

    // The output register can take a new word when it is empty or is being
    // emptied at this edge.
    assign move = rd_valid_reg && (!m_valid_reg || m_ready);

    // Read ahead whenever a stored word is waiting and stage 1 will be free
    // after this edge. This keeps both stages full under continuous traffic.
    assign issue = (unread_reg != '0) && (!rd_valid_reg || move);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        unread_next   = unread_reg;
        rd_valid_next = rd_valid_reg;
        m_valid_next  = m_valid_reg;

        if (flush) begin
            // Flush overrides any push or pop at the same edge.
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            level_next    = '0;
            unread_next   = '0;
            rd_valid_next = 1'b0;
            m_valid_next  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = next_addr(wr_ptr_reg);
            end
            if (issue) begin
                rd_ptr_next = next_addr(rd_ptr_reg);
            end

            unique case ({push, pop})
                2'b10:   level_next = level_reg + LEVEL_ONE;
                2'b01:   level_next = level_reg - LEVEL_ONE;
                default: level_next = level_reg;
            endcase

            unique case ({push, issue})
                2'b10:   unread_next = unread_reg + LEVEL_ONE;
                2'b01:   unread_next = unread_reg - LEVEL_ONE;
                default: unread_next = unread_reg;
            endcase

            if (issue) begin
                rd_valid_next = 1'b1;
            end else if (move) begin
                rd_valid_next = 1'b0;
            end

            if (move) begin
                m_valid_next = 1'b1;
            end else if (pop) begin
                m_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            unread_reg   <= '0;
            rd_valid_reg <= 1'b0;
            m_valid_reg  <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            unread_reg   <= unread_next;
            rd_valid_reg <= rd_valid_next;
            m_valid_reg  <= m_valid_next;
        end
    end

    // Block RAM with registered read, plus the output data register. The data
    // registers carry no reset; their contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= s_data;
        end
        if (issue && !flush && !rst) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
        if (move) begin
            m_data_reg <= rd_data_reg;
        end
    end

    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;
    assign level   = level_reg;

    // Flags compare the registered level, so they change on the same cycle as level.
    assign almost_full  = (int'(level_reg) >= AlmostFullLevel);
    assign almost_empty = (int'(level_reg) <= AlmostEmptyLevel);

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//
// Self-checking bench for stream_fifo. It uses a non-power-of-two depth
// (NumWords=7) with AlmostFullLevel=5 and AlmostEmptyLevel=2. Expected words
// are queued when a push is driven and compared when the DUT pops them. The
// bench keeps a model of the fill level for the flags, level and s_ready.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

    localparam int W  = 8;
    localparam int N  = 7;
    localparam int AF = 5;
    localparam int AE = 2;
    localparam int LW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          almost_empty;

    stream_fifo #(
        .WordLengthBits   (W),
        .NumWords         (N),
        .AlmostFullLevel  (AF),
        .AlmostEmptyLevel (AE)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [W-1:0] exp_q[$];
    int           mdl_level = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs on the falling edge,
    // update the model with the handshakes that occur at the next rising edge.
    task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
        logic do_push;
        logic do_pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(mdl_level != N));
        chk("level", 32'(level), 32'(mdl_level));
        chk("almost_full", 32'(almost_full), 32'(mdl_level >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(mdl_level <= AE));
        if (m_valid) begin
            chk("m_valid_nonempty", 32'(mdl_level != 0), 32'd1);
        end
        if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        do_push = sv && s_ready;
        do_pop  = m_valid && mr;
        if (!fl && do_pop && exp_q.size() != 0) begin
            chk("pop_data", 32'(m_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        prev_stall = m_valid && !mr && !fl;
        prev_data  = m_data;
        if (fl) begin
            exp_q.delete();
        end else if (do_push) begin
            exp_q.push_back(sd);
        end
        mdl_level = exp_q.size();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fall-through latency and hold
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("lat_after_e0", 32'(m_valid), 32'd0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        chk("lat_after_e1", 32'(m_valid), 32'd0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("lat_after_e2", 32'(m_valid), 32'd1);
        chk("head_word", 32'(m_data), 32'h11);
        idle(3);
        chk("level_three", 32'(level), 32'd3);
        drain();

        // Full, pop releases s_ready, then wrap-around traffic
        for (int i = 0; i < 9; i++) begin
            step(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        end
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_level", 32'(level), 32'd7);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ready_after_pop", 32'(s_ready), 32'd1);
        step(1'b1, 8'h50, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(8'h60 + i), 1'b1, 1'b0);
        end
        drain();

        // Flag thresholds: step level 0..7..0
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        drain();

        // Flush has priority over simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            step(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
        end
        idle(2);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_s_ready", 32'(s_ready), 32'd1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(2);
        chk("flush_next_valid", 32'(m_valid), 32'd1);
        chk("flush_next_word", 32'(m_data), 32'hA5);
        drain();

        // Reset mid-operation discards contents
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'(8'hD0 + i), 1'b0, 1'b0);
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        mdl_level  = 0;
        prev_stall = 1'b0;
        step(1'b1, 8'hB7, 1'b0, 1'b0);
        idle(2);
        chk("midrst_next_word", 32'(m_data), 32'hB7);
        drain();

        // Sustained push and pop every cycle
        for (int i = 0; i < 300; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            if (i >= 2) begin
                chk("sus_valid", 32'(m_valid), 32'd1);
                chk("sus_level", 32'(level), 32'd3);
            end
        end
        drain();

        // Random backpressure on both sides
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 55, 1'b0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
